// File: rtl/id_hazard_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// id_hazard_scoreboard_pkg
//   Shared types and constants for the decode-stage hazard scoreboard.
//   - FWD_* : 2-bit forwarding-select encoding used by the decode operand mux
//   - REG_AW: register-file address width
//   - R0    : the hard-wired zero register, never a real dependency
//   - slot_t: shadow record of one in-flight instruction's destination
// ---------------------------------------------------------------------------
package id_hazard_scoreboard_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EXE = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  localparam logic [REG_AW-1:0] R0 = '0;

  typedef struct packed {
    logic              v;      // slot holds a live instruction
    logic              we;     // instruction writes the register file
    logic [REG_AW-1:0] waddr;  // destination register
    logic              ld;     // result comes from memory
  } slot_t;

endpackage

// File: rtl/id_hazard_scoreboard_hz_match.sv
// ---------------------------------------------------------------------------
// hz_match
//   Compares one decode source operand against the EXE, MEM and WB slots.
//   Ports:
//     use_i       - operand is actually read by the instruction
//     raddr_i     - operand source register
//     exe_i/mem_i/wb_i - registered slot records
//     stall_req_o - this operand cannot be satisfied this cycle
//     fwd_sel_o   - operand source (FWD_RF/EXE/MEM/WB)
//   Macro ID_FORWARD_EN: when defined, the youngest hit selects a forwarding
//   source and only a load still in EXE stalls. When undefined, no
//   forwarding exists: fwd_sel_o is FWD_RF and any hit stalls.
// ---------------------------------------------------------------------------
module hz_match
  import id_hazard_scoreboard_pkg::*;
(
  input  logic              use_i,
  input  logic [REG_AW-1:0] raddr_i,
  input  slot_t             exe_i,
  input  slot_t             mem_i,
  input  slot_t             wb_i,
  output logic              stall_req_o,
  output logic [1:0]        fwd_sel_o
);

  logic rd_ok;
  logic hit_exe;
  logic hit_mem;
  logic hit_wb;

  // r0 reads are constant zero, so a write to r0 is never a dependency.
  assign rd_ok   = use_i & (raddr_i != R0);
  assign hit_exe = rd_ok & exe_i.v & exe_i.we & (exe_i.waddr == raddr_i);
  assign hit_mem = rd_ok & mem_i.v & mem_i.we & (mem_i.waddr == raddr_i);
  assign hit_wb  = rd_ok & wb_i.v  & wb_i.we  & (wb_i.waddr  == raddr_i);

`ifdef ID_FORWARD_EN
  // Youngest producer holds the architecturally newest value.
  always_comb begin
    fwd_sel_o = FWD_RF;
    if (hit_exe)      fwd_sel_o = FWD_EXE;
    else if (hit_mem) fwd_sel_o = FWD_MEM;
    else if (hit_wb)  fwd_sel_o = FWD_WB;
  end

  // Load data only exists once the load reaches MEM.
  assign stall_req_o = hit_exe & exe_i.ld;
`else
  logic unused_ld;

  assign fwd_sel_o   = FWD_RF;
  assign stall_req_o = hit_exe | hit_mem | hit_wb;
  assign unused_ld   = exe_i.ld ^ mem_i.ld ^ wb_i.ld;
`endif

endmodule

// File: rtl/id_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// id_hazard_scoreboard
//   Interlock / forwarding controller for the decode stage of a 5-stage
//   LoongArch pipeline. Shadows the destination of the instructions in EXE,
//   MEM and WB and compares them with the decode source operands.
//   Ports:
//     clk, resetn            - clock (rising edge), async active-low reset
//     id_*                   - decode-stage instruction description
//     exe_allowin            - EXE accepts an instruction this cycle
//     exe_to_mem_fire        - EXE->MEM handshake
//     mem_to_wb_fire         - MEM->WB handshake
//     wb_retire              - WB instruction writes back
//     flush                  - kill EXE and MEM (WB still commits)
//     id_stall               - decode must hold (ready_go = ~id_stall)
//     fwd_sel1 / fwd_sel2    - rj / rkd source select
//     stall_cnt              - saturating count of stalled decode cycles
//   Macro ID_FORWARD_EN enables forwarding (see hz_match); slot tracking and
//   the counter are the same in both builds.
// ---------------------------------------------------------------------------
module id_hazard_scoreboard
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_raddr1,
  input  logic [REG_AW-1:0] id_raddr2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic              id_rf_we,
  input  logic [REG_AW-1:0] id_rf_waddr,
  input  logic              id_is_load,
  input  logic              exe_allowin,
  input  logic              exe_to_mem_fire,
  input  logic              mem_to_wb_fire,
  input  logic              wb_retire,
  input  logic              flush,
  output logic              id_stall,
  output logic [1:0]        fwd_sel1,
  output logic [1:0]        fwd_sel2,
  output logic [CNT_W-1:0]  stall_cnt
);

  slot_t            exe_q, exe_d;
  slot_t            mem_q, mem_d;
  slot_t            wb_q,  wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req1;
  logic             req2;
  logic             id_fire;

  hz_match u_match1 (
    .use_i       (id_use1),
    .raddr_i     (id_raddr1),
    .exe_i       (exe_q),
    .mem_i       (mem_q),
    .wb_i        (wb_q),
    .stall_req_o (req1),
    .fwd_sel_o   (fwd_sel1)
  );

  hz_match u_match2 (
    .use_i       (id_use2),
    .raddr_i     (id_raddr2),
    .exe_i       (exe_q),
    .mem_i       (mem_q),
    .wb_i        (wb_q),
    .stall_req_o (req2),
    .fwd_sel_o   (fwd_sel2)
  );

  assign id_stall  = id_valid & (req1 | req2);
  assign id_fire   = id_valid & ~id_stall & exe_allowin;
  assign stall_cnt = cnt_q;

  always_comb begin
    exe_d = exe_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    cnt_d = cnt_q;

    if (flush)                exe_d = '0;
    else if (id_fire)         exe_d = '{v: 1'b1, we: id_rf_we, waddr: id_rf_waddr, ld: id_is_load};
    else if (exe_to_mem_fire) exe_d.v = 1'b0;

    if (flush)                mem_d = '0;
    else if (exe_to_mem_fire) mem_d = exe_q;
    else if (mem_to_wb_fire)  mem_d.v = 1'b0;

    // WB samples the pre-flush MEM record: an instruction leaving MEM in the
    // flush cycle has already passed the kill point and must commit.
    if (mem_to_wb_fire)       wb_d = mem_q;
    else if (wb_retire)       wb_d.v = 1'b0;

    if (id_valid && id_stall && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exe_q <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      exe_q <= exe_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
module tb_id_hazard_scoreboard;

`ifdef ID_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          id_valid;
  logic [4:0]    id_raddr1, id_raddr2, id_rf_waddr;
  logic          id_use1, id_use2, id_rf_we, id_is_load;
  logic          exe_allowin, exe_to_mem_fire, mem_to_wb_fire, wb_retire, flush;
  logic          id_stall;
  logic [1:0]    fwd_sel1, fwd_sel2;
  logic [CW-1:0] stall_cnt;

  id_hazard_scoreboard #(.CNT_W(CW)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .id_valid        (id_valid),
    .id_raddr1       (id_raddr1),
    .id_raddr2       (id_raddr2),
    .id_use1         (id_use1),
    .id_use2         (id_use2),
    .id_rf_we        (id_rf_we),
    .id_rf_waddr     (id_rf_waddr),
    .id_is_load      (id_is_load),
    .exe_allowin     (exe_allowin),
    .exe_to_mem_fire (exe_to_mem_fire),
    .mem_to_wb_fire  (mem_to_wb_fire),
    .wb_retire       (wb_retire),
    .flush           (flush),
    .id_stall        (id_stall),
    .fwd_sel1        (fwd_sel1),
    .fwd_sel2        (fwd_sel2),
    .stall_cnt       (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic          st;
    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          q[$];
  int            ntests = 0;
  int            nfail  = 0;
  logic [CW-1:0] exp_cnt = '0;

  task automatic push_exp(input string tag, input logic st, input logic [1:0] s1,
                          input logic [1:0] s2);
    exp_t e;
    e.tag = tag; e.st = st; e.s1 = s1; e.s2 = s2; e.cnt = exp_cnt;
    q.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    ntests++;
    assert (q.size() != 0) else begin
      nfail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      ntests++;
      assert (id_stall === e.st) else begin
        nfail++;
        $error("FAIL %s.id_stall observed=%0b expected=%0b", e.tag, id_stall, e.st);
      end
      ntests++;
      assert (fwd_sel1 === e.s1) else begin
        nfail++;
        $error("FAIL %s.fwd_sel1 observed=%0d expected=%0d", e.tag, fwd_sel1, e.s1);
      end
      ntests++;
      assert (fwd_sel2 === e.s2) else begin
        nfail++;
        $error("FAIL %s.fwd_sel2 observed=%0d expected=%0d", e.tag, fwd_sel2, e.s2);
      end
      ntests++;
      assert (stall_cnt === e.cnt) else begin
        nfail++;
        $error("FAIL %s.stall_cnt observed=%0d expected=%0d", e.tag, stall_cnt, e.cnt);
      end
    end
  endtask

  // One clock cycle: drive decode + control, push expectation, compare on
  // the falling edge, then let the rising edge update the slots.
  task automatic step(input string tag,
                      input logic v, input logic [4:0] r1, input logic [4:0] r2,
                      input logic u1, input logic u2, input logic we,
                      input logic [4:0] wa, input logic ld,
                      input logic al, input logic e2m, input logic m2w,
                      input logic ret, input logic fl,
                      input logic est, input logic [1:0] e1, input logic [1:0] e2);
    id_valid = v; id_raddr1 = r1; id_raddr2 = r2; id_use1 = u1; id_use2 = u2;
    id_rf_we = we; id_rf_waddr = wa; id_is_load = ld;
    exe_allowin = al; exe_to_mem_fire = e2m; mem_to_wb_fire = m2w;
    wb_retire = ret; flush = fl;
    push_exp(tag, est, e1, e2);
    @(negedge clk);
    pop_cmp();
    if (v && est && exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    id_valid = 1'b1; id_raddr1 = 5'd5; id_raddr2 = 5'd7; id_use1 = 1'b1; id_use2 = 1'b1;
    id_rf_we = 1'b0; id_rf_waddr = '0; id_is_load = 1'b0;
    exe_allowin = 1'b0; exe_to_mem_fire = 1'b0; mem_to_wb_fire = 1'b0;
    wb_retire = 1'b0; flush = 1'b0;
    #2;
    push_exp("reset", 1'b0, 2'd0, 2'd0);
    pop_cmp();
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    //     tag            v  r1 r2 u1 u2 we wa ld  al e2m m2w ret fl   est        s1              s2
    step("alu_issue",    1, 0, 0, 0, 0, 1, 5, 0,  1, 0,  0,  0,  0,  0,         2'd0,           2'd0);
    step("alu_exe",      1, 5, 0, 1, 0, 0, 0, 0,  0, 1,  0,  0,  0,  !FWD,      FWD ? 2'd1 : 2'd0, 2'd0);
    step("alu_mem",      1, 5, 0, 1, 0, 0, 0, 0,  0, 0,  1,  0,  0,  !FWD,      FWD ? 2'd2 : 2'd0, 2'd0);
    step("alu_wb",       1, 5, 0, 1, 0, 0, 0, 0,  0, 0,  0,  1,  0,  !FWD,      FWD ? 2'd3 : 2'd0, 2'd0);
    step("alu_rf",       1, 5, 0, 1, 0, 0, 0, 0,  0, 0,  0,  0,  0,  0,         2'd0,           2'd0);

    step("ld_issue",     1, 0, 0, 0, 0, 1, 7, 1,  1, 0,  0,  0,  0,  0,         2'd0,           2'd0);
    step("ld_use0",      1, 0, 7, 0, 1, 0, 0, 0,  1, 0,  0,  0,  0,  1,         2'd0,           FWD ? 2'd1 : 2'd0);
    step("ld_use1",      1, 0, 7, 0, 1, 0, 0, 0,  1, 1,  0,  0,  0,  1,         2'd0,           FWD ? 2'd1 : 2'd0);
    step("ld_mem",       1, 0, 7, 0, 1, 0, 0, 0,  0, 0,  1,  0,  0,  !FWD,      2'd0,           FWD ? 2'd2 : 2'd0);
    step("ld_wb",        0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0,  1,  0,  0,         2'd0,           2'd0);

    step("pri_issue3",   1, 0, 0, 0, 0, 1, 3, 0,  1, 0,  0,  0,  0,  0,         2'd0,           2'd0);
    step("pri_issue9",   1, 0, 0, 0, 0, 1, 9, 0,  1, 1,  0,  0,  0,  0,         2'd0,           2'd0);
    step("pri_reissue3", 1, 0, 0, 0, 0, 1, 3, 0,  1, 0,  1,  0,  0,  0,         2'd0,           2'd0);
    step("pri_exe_wb",   1, 3, 0, 1, 1, 0, 0, 0,  0, 0,  0,  0,  0,  !FWD,      FWD ? 2'd1 : 2'd0, 2'd0);
    step("issue6",       1, 0, 0, 0, 0, 1, 6, 0,  1, 0,  0,  0,  0,  0,         2'd0,           2'd0);
    step("indep",        1, 3, 6, 1, 1, 0, 0, 0,  0, 0,  0,  0,  0,  !FWD,      FWD ? 2'd3 : 2'd0, FWD ? 2'd1 : 2'd0);
    step("issue_r0",     1, 0, 0, 0, 0, 1, 0, 0,  1, 0,  0,  0,  0,  0,         2'd0,           2'd0);
    step("r0_read",      1, 0, 0, 1, 1, 1, 8, 0,  0, 0,  0,  0,  0,  0,         2'd0,           2'd0);
    step("hold_no_fire", 1, 8, 0, 1, 0, 0, 0, 0,  0, 0,  0,  0,  0,  0,         2'd0,           2'd0);
    step("invalid_read", 0, 3, 0, 1, 0, 0, 0, 0,  0, 0,  0,  1,  1,  0,         FWD ? 2'd3 : 2'd0, 2'd0);

    step("fl_issue",     1, 0, 0, 0, 0, 1, 4, 0,  1, 0,  0,  0,  0,  0,         2'd0,           2'd0);
    step("fl_issue2",    1, 0, 0, 0, 0, 1, 4, 0,  1, 1,  0,  0,  0,  0,         2'd0,           2'd0);
    step("fl_issue3",    1, 0, 0, 0, 0, 1, 4, 0,  1, 1,  1,  0,  0,  0,         2'd0,           2'd0);
    step("fl_flush",     0, 4, 0, 1, 0, 0, 0, 0,  0, 0,  0,  0,  1,  0,         FWD ? 2'd1 : 2'd0, 2'd0);
    step("fl_after",     1, 4, 0, 1, 0, 0, 0, 0,  0, 0,  0,  0,  0,  !FWD,      FWD ? 2'd3 : 2'd0, 2'd0);
    step("clr",          0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0,  1,  0,  0,         2'd0,           2'd0);

    step("sat_issue",    1, 0, 0, 0, 0, 1, 7, 1,  1, 0,  0,  0,  0,  0,         2'd0,           2'd0);
    for (int i = 0; i < 20; i++)
      step("sat_stall",  1, 0, 7, 0, 1, 0, 0, 0,  1, 0,  0,  0,  0,  1,         2'd0,           FWD ? 2'd1 : 2'd0);
    ntests++;
    assert (stall_cnt === 4'd15) else begin
      nfail++;
      $error("FAIL sat_final observed=%0d expected=15", stall_cnt);
    end

    // Asynchronous reset in the middle of a stall, well before the next edge.
    #1;
    push_exp("pre_rst", 1'b1, 2'd0, FWD ? 2'd1 : 2'd0);
    pop_cmp();
    resetn = 1'b0;
    exp_cnt = '0;
    #1;
    push_exp("async_rst", 1'b0, 2'd0, 2'd0);
    pop_cmp();
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    step("post_rst",     1, 0, 7, 0, 1, 0, 0, 0,  1, 0,  0,  0,  0,  0,         2'd0,           2'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
